// File: rtl/dmem_req_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory request controller:
// FSM state encodings, SRAM-like data_size codes, KSEG segment constants
// and the byte-lane to transfer-size helper.
package dmem_req_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Top three address bits of the unmapped kernel segments
  localparam logic [2:0] SEG_KSEG0 = 3'b100;
  localparam logic [2:0] SEG_KSEG1 = 3'b101;

  // Irregular lane patterns fall back to a full-word transfer
  function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
    logic [1:0] size;
    size = SIZE_WORD;
    case (sel)
      4'b1111:                            size = SIZE_WORD;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      default:                            size = SIZE_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/dmem_req_ctrl_if.sv
// SRAM-like data port between the request controller (master) and the
// AXI bridge (slave).
interface dmem_req_ctrl_if #(
  parameter int ADDR_W = 32
) ();

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/dmem_size_dec.sv
// Combinational decode of the MEM-stage byte-lane select into a transfer
// size, plus the virtual-to-physical map for kseg0/kseg1 addresses.
// The low address bits always pass through untouched.
module dmem_size_dec
  import dmem_req_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] vaddr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] paddr
);

  logic kseg_hit;

  assign data_size = sel_to_size(mem_sel);

  if (KSEG_MAP) begin : g_map
    assign kseg_hit = (vaddr[ADDR_W-1 -: 3] == SEG_KSEG0) ||
                      (vaddr[ADDR_W-1 -: 3] == SEG_KSEG1);
  end else begin : g_nomap
    assign kseg_hit = 1'b0;
  end

  assign paddr[ADDR_W-4:0] = vaddr[ADDR_W-4:0];

  // Segment bits are cleared for kseg0/kseg1, giving the physical window
  for (genvar gi = ADDR_W - 3; gi < ADDR_W; gi++) begin : g_seg
    assign paddr[gi] = vaddr[gi] & ~kseg_hit;
  end

endmodule

// File: rtl/dmem_req_ctrl.sv
// MEM-stage data-memory request controller. Issues one SRAM-like access
// at a time, holds the pipeline until it completes and returns the raw
// read word. A flushed access cannot be withdrawn from the bridge, so it
// is marked dropped and its response is swallowed before anything new
// is issued.
module dmem_req_ctrl
  import dmem_req_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_valid,
  input  logic                  mem_wr,
  input  logic [3:0]            mem_sel,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic                  mem_flush,
  input  logic                  mem_adv,
  output logic                  stall_mem,
  output logic [31:0]           rdata_out,
  dmem_req_ctrl_if.master       dport
);

  state_t            state_reg, state_next;
  logic              drop_reg, drop_next;
  logic              wr_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;

  logic [1:0]        dec_size;
  logic [ADDR_W-1:0] dec_addr;
  logic              need;
  logic              issue;
  logic              resp;
  logic              discard;
  logic              req_out;

  dmem_size_dec #(
    .ADDR_W   (ADDR_W),
    .KSEG_MAP (KSEG_MAP)
  ) u_size_dec (
    .mem_sel   (mem_sel),
    .vaddr     (mem_addr),
    .data_size (dec_size),
    .paddr     (dec_addr)
  );

  assign need    = mem_valid & (|mem_sel) & ~mem_flush;
  // No new issue while a dropped access is still owed a response
  assign issue   = (state_reg == ST_IDLE) & need & ~drop_reg;
  // Response of the outstanding access arrives this cycle
  assign resp    = ((state_reg == ST_REQ) & dport.data_addr_ok & dport.data_data_ok) |
                   ((state_reg == ST_WAIT) & dport.data_data_ok);
  // A flush landing on the response cycle kills it just like an earlier one
  assign discard = resp & (drop_reg | mem_flush);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (issue) state_next = ST_REQ;
      ST_REQ: begin
        if (dport.data_addr_ok) begin
          if (dport.data_data_ok) state_next = discard ? ST_IDLE : ST_DONE;
          else                    state_next = ST_WAIT;
        end
      end
      ST_WAIT: if (dport.data_data_ok) state_next = discard ? ST_IDLE : ST_DONE;
      ST_DONE: if (mem_adv || mem_flush) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req_out   = 1'b0;
    stall_mem = 1'b0;
    req_out   = (state_reg == ST_REQ);
    stall_mem = (need & (state_reg != ST_DONE)) |
                ((state_reg == ST_IDLE) & drop_reg) |
                ((state_reg != ST_IDLE) & (state_reg != ST_DONE) & drop_reg & need);
  end

  // Drop flag: set by a flush while the bridge still owes a response
  always_comb begin
    drop_next = drop_reg;
    if (resp) drop_next = 1'b0;
    else if (mem_flush && (state_reg == ST_REQ || state_reg == ST_WAIT)) drop_next = 1'b1;
  end

  // Drop flag register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) drop_reg <= 1'b0;
    else         drop_reg <= drop_next;
  end

  // Request fields are latched on issue and held until the next issue
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_reg    <= 1'b0;
      size_reg  <= SIZE_BYTE;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (issue) begin
      wr_reg    <= mem_wr;
      size_reg  <= dec_size;
      addr_reg  <= dec_addr;
      wdata_reg <= mem_wdata;
    end
  end

  // Read word captured only for kept loads; stores leave it unchanged
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                         rdata_reg <= '0;
    else if (resp && !discard && !wr_reg) rdata_reg <= dport.data_rdata;
  end

  assign rdata_out        = rdata_reg;
  assign dport.data_req   = req_out;
  assign dport.data_wr    = wr_reg;
  assign dport.data_size  = size_reg;
  assign dport.data_addr  = addr_reg;
  assign dport.data_wdata = wdata_reg;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Bench for dmem_req_ctrl: a table of accesses served by an inline bridge
// model with per-access addr_ok/data_ok delays, a scoreboard of expected
// requests, and hand-written sequences for reset, adelM, flush-in-WAIT
// and reset-in-WAIT.
module tb_dmem_req_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_wr = 1'b0;
  logic [3:0]  mem_sel = 4'b0000;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_flush = 1'b0;
  logic        mem_adv = 1'b0;
  logic        stall_mem;
  logic [31:0] rdata_out;

  always #5 clk = ~clk;

  dmem_req_ctrl_if #(.ADDR_W(32)) dif ();

  dmem_req_ctrl #(.ADDR_W(32), .KSEG_MAP(1'b1)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_wr    (mem_wr),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_flush (mem_flush),
    .mem_adv   (mem_adv),
    .stall_mem (stall_mem),
    .rdata_out (rdata_out),
    .dport     (dif)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        wr;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          aok_dly;
    int          dok_dly;
    logic [1:0]  exp_size;
    logic [31:0] exp_paddr;
    logic [31:0] exp_rout;
  } vec_t;

  req_t exp_q[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  task automatic bridge_idle();
    dif.data_addr_ok = 1'b0;
    dif.data_data_ok = 1'b0;
    dif.data_rdata   = 32'hBAD0_BAD0;
  endtask

  task automatic step();
    @(negedge clk);
    bridge_idle();
  endtask

  // Compare the request currently on the port against the oldest expectation
  task automatic pop_req(input string tag);
    req_t e;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_wr"},    32'(dif.data_wr),   32'(e.wr));
      chk({tag, "_size"},  32'(dif.data_size), 32'(e.size));
      chk({tag, "_addr"},  dif.data_addr,      e.addr);
      chk({tag, "_wdata"}, dif.data_wdata,     e.wdata);
    end
  endtask

  task automatic do_access(input vec_t v, input int idx);
    req_t        e;
    logic [31:0] first_addr;
    bit          stable, req_in_wait, done;
    int          phase, stall_cnt, req_cyc, wait_cnt;
    string       tag;
    tag = $sformatf("v%0d", idx);
    e.wr = v.wr; e.size = v.exp_size; e.addr = v.exp_paddr; e.wdata = v.wdata;
    exp_q.push_back(e);
    step();
    mem_valid = 1'b1; mem_wr = v.wr; mem_sel = v.sel; mem_addr = v.addr;
    mem_wdata = v.wdata; mem_flush = 1'b0; mem_adv = 1'b0;
    phase = 0; stall_cnt = 0; req_cyc = 0; wait_cnt = 0;
    stable = 1'b1; req_in_wait = 1'b0; done = 1'b0; first_addr = 32'h0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) step();
      #1;
      if (phase == 3) begin
        chk({tag, "_done_stall"}, 32'(stall_mem), 32'd0);
        chk({tag, "_rdata_out"}, rdata_out, v.exp_rout);
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(2 + v.aok_dly + v.dok_dly));
        chk({tag, "_req_stable"}, 32'(stable), 32'd1);
        chk({tag, "_req_low_in_wait"}, 32'(req_in_wait), 32'd0);
        mem_adv = 1'b1;
        done = 1'b1;
      end else begin
        if (stall_mem) stall_cnt++;
        if (phase == 0 && dif.data_req) begin
          pop_req(tag);
          first_addr = dif.data_addr;
          phase = 1;
        end
        if (phase == 1) begin
          if (!dif.data_req || dif.data_addr !== first_addr) stable = 1'b0;
          if (req_cyc == v.aok_dly) begin
            dif.data_addr_ok = 1'b1;
            if (v.dok_dly == 0) begin
              dif.data_data_ok = 1'b1; dif.data_rdata = v.rdata; phase = 3;
            end else begin
              phase = 2;
            end
          end
          req_cyc++;
        end else if (phase == 2) begin
          if (dif.data_req) req_in_wait = 1'b1;
          wait_cnt++;
          if (wait_cnt == v.dok_dly) begin
            dif.data_data_ok = 1'b1; dif.data_rdata = v.rdata; phase = 3;
          end
        end
      end
    end
    chk({tag, "_completed"}, 32'(done), 32'd1);
    $display("txn %s: wr=%0b sel=%b addr=%08h stall=%0d rdata_out=%08h",
             tag, v.wr, v.sel, v.addr, stall_cnt, rdata_out);
    step();
    mem_valid = 1'b0; mem_adv = 1'b0; mem_sel = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    req_t        e;
    bit          req_seen, stall_seen;
    logic [31:0] prev;

    vecs[0] = '{1'b0, 4'b1111, 32'h8000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 4'b0100, 32'hA000_0002, 32'h5A5A_5A5A, 32'h1111_1111, 3, 1, 2'd0, 32'h0000_0002, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 4'b1111, 32'h0000_1000, 32'h0000_0000, 32'hCAFE_F00D, 1, 3, 2'd2, 32'h0000_1000, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 4'b1100, 32'h9FC0_0006, 32'h0000_0000, 32'h1234_5678, 0, 2, 2'd1, 32'h1FC0_0006, 32'h1234_5678};
    vecs[4] = '{1'b1, 4'b0011, 32'hC000_0000, 32'hABCD_ABCD, 32'h0000_0000, 2, 0, 2'd1, 32'hC000_0000, 32'h1234_5678};
    vecs[5] = '{1'b0, 4'b0110, 32'hBFC0_0001, 32'h0000_0000, 32'h0F0F_0F0F, 0, 1, 2'd2, 32'h1FC0_0001, 32'h0F0F_0F0F};
    vecs[6] = '{1'b0, 4'b1000, 32'h0000_0003, 32'h0000_0000, 32'h8899_AABB, 0, 0, 2'd0, 32'h0000_0003, 32'h8899_AABB};

    bridge_idle();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_data_req",   32'(dif.data_req),  32'd0);
    chk("rst_stall",      32'(stall_mem),     32'd0);
    chk("rst_rdata_out",  rdata_out,          32'd0);
    chk("rst_data_wr",    32'(dif.data_wr),   32'd0);
    chk("rst_data_size",  32'(dif.data_size), 32'd0);
    chk("rst_data_addr",  dif.data_addr,      32'd0);
    chk("rst_data_wdata", dif.data_wdata,     32'd0);
    $display("txn reset: rdata_out=%08h", rdata_out);
    step();
    resetn = 1'b1;

    for (int i = 0; i < 7; i++) do_access(vecs[i], i);

    // adelM: valid op with no lanes must never reach the bus
    step();
    mem_valid = 1'b1; mem_wr = 1'b0; mem_sel = 4'b0000; mem_addr = 32'h8000_0001;
    req_seen = 1'b0; stall_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      #1;
      req_seen   |= dif.data_req;
      stall_seen |= stall_mem;
    end
    chk("adel_req",   32'(req_seen),   32'd0);
    chk("adel_stall", 32'(stall_seen), 32'd0);
    $display("txn adel: req_seen=%0b stall_seen=%0b", req_seen, stall_seen);
    step();
    mem_valid = 1'b0;

    // Flush in WAIT, then a new load waits for the dropped response
    prev = vecs[6].exp_rout;
    e = '{1'b0, 2'd2, 32'h0000_0100, 32'h0}; exp_q.push_back(e);
    step();
    mem_valid = 1'b1; mem_wr = 1'b0; mem_sel = 4'b1111; mem_addr = 32'h0000_0100; mem_wdata = 32'h0;
    #1;
    step(); #1;
    pop_req("fl_old");
    dif.data_addr_ok = 1'b1;
    step(); #1;
    mem_flush = 1'b1; mem_valid = 1'b0;
    step();
    mem_flush = 1'b0; mem_valid = 1'b1; mem_addr = 32'h0000_0200;
    e = '{1'b0, 2'd2, 32'h0000_0200, 32'h0}; exp_q.push_back(e);
    #1;
    chk("fl_drop_stall", 32'(stall_mem),    32'd1);
    chk("fl_drop_noreq", 32'(dif.data_req), 32'd0);
    step(); #1;
    chk("fl_drop_noreq2", 32'(dif.data_req), 32'd0);
    dif.data_data_ok = 1'b1; dif.data_rdata = 32'h6666_6666;
    step(); #1;
    chk("fl_rdata_kept", rdata_out,          prev);
    chk("fl_idle_stall", 32'(stall_mem),     32'd1);
    chk("fl_idle_noreq", 32'(dif.data_req),  32'd0);
    step(); #1;
    chk("fl_new_req", 32'(dif.data_req), 32'd1);
    pop_req("fl_new");
    dif.data_addr_ok = 1'b1; dif.data_data_ok = 1'b1; dif.data_rdata = 32'h1357_9BDF;
    step(); #1;
    chk("fl_new_stall", 32'(stall_mem), 32'd0);
    chk("fl_new_rdata", rdata_out,      32'h1357_9BDF);
    $display("txn flush: rdata_out=%08h", rdata_out);
    mem_adv = 1'b1;
    step();
    mem_adv = 1'b0; mem_valid = 1'b0;

    // Reset pulsed during WAIT, then a normal load
    e = '{1'b0, 2'd2, 32'h0000_0300, 32'h0}; exp_q.push_back(e);
    step();
    mem_valid = 1'b1; mem_sel = 4'b1111; mem_addr = 32'h8000_0300;
    #1;
    step(); #1;
    pop_req("rw");
    dif.data_addr_ok = 1'b1;
    step(); #1;
    resetn = 1'b0;
    #1;
    chk("rw_req",   32'(dif.data_req), 32'd0);
    chk("rw_addr",  dif.data_addr,     32'd0);
    chk("rw_rdata", rdata_out,         32'd0);
    $display("txn reset_wait: data_addr=%08h rdata_out=%08h", dif.data_addr, rdata_out);
    step();
    resetn = 1'b1; mem_valid = 1'b0;
    do_access('{1'b0, 4'b1111, 32'hBFC0_0100, 32'h0, 32'h2468_ACE0, 0, 1, 2'd2, 32'h1FC0_0100, 32'h2468_ACE0}, 7);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
